// File: rtl/clock_run_ctrl_pkg.sv
// Shared types and defaults for the CPU clock run/halt/step controller.
package clock_run_ctrl_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int DIV_DEF   = 5;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_STOP = 2'd3
    } state_t;

endpackage

// File: rtl/clock_run_ctrl_if.sv
// Operator/CPU request inputs and generated clock outputs of clock_run_ctrl.
interface clock_run_ctrl_if
    import clock_run_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             run_req;
    logic             step_req;
    logic             halt_in;
    logic             div_wr;
    logic [CNT_W-1:0] div_in;
    logic             clock;
    logic             clk_en;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] cur_div;

    modport master (
        output run_req, step_req, halt_in, div_wr, div_in,
        input  clock, clk_en, state_out, cur_div
    );

    modport slave (
        input  run_req, step_req, halt_in, div_wr, div_in,
        output clock, clk_en, state_out, cur_div
    );
endinterface

// File: rtl/clock_run_ctrl_half_counter.sv
// Half-period counter: pulses o_tgl on the cycle the count reaches i_div.
module clk_half_counter
    import clock_run_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tgl,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    assign o_tgl = i_en && (r_cnt == i_div);
    assign o_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tgl ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/clock_run_ctrl.sv
// Run/halt/single-step controller producing the divided CPU clock and its
// rising-edge enable, with glitch-free runtime divisor changes.
module clock_run_ctrl
    import clock_run_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    clock_run_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    state_t           r_state;
    state_t           w_next;
    logic             r_clock;
    logic             r_clk_en;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_cnt;
    logic             w_tgl;
    logic             w_en;
    logic             w_clr;
    logic             w_fall;
    logic             w_rise;
    logic             w_apply;

    assign w_en    = (r_state != ST_HALT);
    assign w_fall  = w_tgl && r_clock;
    // A rise that would land in STOP is cancelled; STOP only finishes a high half.
    assign w_rise  = w_tgl && !r_clock && (r_state != ST_STOP);
    assign w_clr   = (r_state == ST_HALT) || (w_next == ST_HALT);
    assign w_apply = (r_state == ST_HALT) || w_fall;

    clk_half_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_en),
        .i_clr (w_clr),
        .i_div (r_active),
        .o_tgl (w_tgl),
        .o_cnt (w_cnt)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_HALT: begin
                if (bus.run_req && !bus.halt_in) w_next = ST_RUN;
                else if (bus.step_req)           w_next = ST_STEP;
            end
            ST_RUN: begin
                if (!bus.run_req || bus.halt_in) w_next = ST_STOP;
            end
            ST_STEP: begin
                if (w_fall) w_next = ST_HALT;
            end
            ST_STOP: begin
                if (!r_clock || w_fall) w_next = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_HALT;
            r_clock   <= 1'b0;
            r_clk_en  <= 1'b0;
            r_active  <= DIV_RST;
            r_pending <= DIV_RST;
        end else begin
            r_state  <= w_next;
            r_clk_en <= w_rise;
            if ((r_state == ST_HALT) || w_fall) r_clock <= 1'b0;
            else if (w_rise)                    r_clock <= 1'b1;
            if (w_apply)    r_active  <= r_pending;
            if (bus.div_wr) r_pending <= bus.div_in;
        end
    end

    a_cnt_in_range: assert property (
        @(posedge clk) disable iff (reset) w_cnt <= r_active
    );

    assign bus.clock     = r_clock;
    assign bus.clk_en    = r_clk_en;
    assign bus.state_out = r_state;
    assign bus.cur_div   = r_active;
endmodule

// File: tb/tb_clock_run_ctrl.sv
// Directed bench for clock_run_ctrl with a cycle model compared every clock.
module tb_clock_run_ctrl;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    clock_run_ctrl_if #(.CNT_W(W)) bus ();

    clock_run_ctrl #(.CNT_W(W), .DEFAULT_DIV(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Model: state as an integer, time left in the half period as a countdown.
    int          m_st;
    bit          m_clk;
    bit          m_en;
    int unsigned m_act;
    int unsigned m_pend;
    int unsigned m_left;
    bit          m_ok = 1'b0;

    always @(posedge clk) begin : model
        bit          tog;
        bit          fall;
        bit          rise;
        bit          oclk;
        int          nst;
        int unsigned nact;
        if (reset) begin
            m_st   = 0;
            m_clk  = 1'b0;
            m_en   = 1'b0;
            m_act  = 5;
            m_pend = 5;
            m_left = 6;
            m_ok   = 1'b1;
        end else begin
            tog  = (m_st != 0) && (m_left == 1);
            oclk = m_clk;
            fall = tog && oclk;
            rise = tog && !oclk && (m_st != 3);
            nact = (m_st == 0 || fall) ? m_pend : m_act;
            if (bus.div_wr) m_pend = bus.div_in;
            m_en = rise;
            if (fall)      m_clk = 1'b0;
            else if (rise) m_clk = 1'b1;
            case (m_st)
                0:       nst = (bus.run_req && !bus.halt_in) ? 1 :
                               (bus.step_req ? 2 : 0);
                1:       nst = (!bus.run_req || bus.halt_in) ? 3 : 1;
                2:       nst = fall ? 0 : 2;
                default: nst = (!oclk || fall) ? 0 : 3;
            endcase
            if (m_st == 0 || nst == 0 || tog) m_left = nact + 1;
            else                              m_left = m_left - 1;
            m_st  = nst;
            m_act = nact;
        end
    end

    always @(posedge clk) begin : compare
        logic [W+3:0] got;
        logic [W+3:0] exp;
        #2;
        if (m_ok) begin
            got = {bus.state_out, bus.clock, bus.clk_en, bus.cur_div};
            exp = {m_st[1:0], m_clk, m_en, m_act};
            vecs++;
            if (got !== exp) begin
                errs++;
                $display("FAIL cycle @%0t: got st=%0d clock=%0b en=%0b div=%0d, expected st=%0d clock=%0b en=%0b div=%0d",
                         $time, bus.state_out, bus.clock, bus.clk_en, bus.cur_div,
                         m_st, m_clk, m_en, m_act);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_div(input logic [W-1:0] v);
        bus.div_wr = 1'b1;
        bus.div_in = v;
        tick(1);
        bus.div_wr = 1'b0;
        tick(2);
    endtask

    initial begin
        int first;
        int mfirst;
        int n;
        int mn;
        int hi;
        bus.run_req  = 1'b0;
        bus.step_req = 1'b0;
        bus.halt_in  = 1'b0;
        bus.div_wr   = 1'b0;
        bus.div_in   = '0;
        tick(3);
        reset = 1'b0;
        tick(20);
        chk("rst_clock", 32'(bus.clock), 0);
        chk("rst_en", 32'(bus.clk_en), 0);
        chk("rst_state", 32'(bus.state_out), 0);
        chk("rst_div", bus.cur_div, 5);
        chk("rst_div_mdl", m_act, 5);

        set_div(2);
        chk("div2_halt", bus.cur_div, 2);

        // Continuous run, DIV=2: first rise 3 cycles after entry, period 6.
        bus.run_req = 1'b1;
        first = 0; mfirst = 0; n = 0; mn = 0;
        for (int k = 1; k <= 64; k++) begin
            tick(1);
            if (bus.clk_en && first == 0) first = k;
            if (m_en && mfirst == 0) mfirst = k;
            if (k > 4 && bus.clk_en) n++;
            if (k > 4 && m_en) mn++;
            if (k == 1) chk("run_entry_state", 32'(bus.state_out), 1);
            if (k == 5) chk("run_en_one_cycle", 32'(bus.clk_en), 0);
        end
        chk("run_first_rise", first, 4);
        chk("run_first_rise_mdl", mfirst, 4);
        chk("run_10_periods", n, 10);
        chk("run_10_periods_mdl", mn, 10);
        chk("run_clock_high", 32'(bus.clock), 1);

        // Stop while high: finish the 3-cycle high half, then HALT.
        bus.run_req = 1'b0;
        tick(1);
        chk("stop_hi_state", 32'(bus.state_out), 3);
        chk("stop_hi_clock1", 32'(bus.clock), 1);
        tick(1);
        chk("stop_hi_clock2", 32'(bus.clock), 1);
        tick(1);
        chk("stop_hi_halt", 32'(bus.state_out), 0);
        chk("stop_hi_fall", 32'(bus.clock), 0);

        // Stop while low, on the cycle a rise would have been due.
        bus.run_req = 1'b1;
        tick(8);
        chk("stop_lo_pre", 32'(bus.clock), 0);
        bus.run_req = 1'b0;
        tick(1);
        chk("stop_lo_state", 32'(bus.state_out), 3);
        tick(1);
        chk("stop_lo_halt", 32'(bus.state_out), 0);
        chk("stop_lo_clock", 32'(bus.clock), 0);
        chk("stop_lo_no_en", 32'(bus.clk_en), 0);

        // Single step, DIV=2, with a second step request mid-step.
        tick(2);
        bus.step_req = 1'b1;
        tick(1);
        bus.step_req = 1'b0;
        chk("step_state", 32'(bus.state_out), 2);
        tick(1);
        bus.step_req = 1'b1;
        tick(1);
        bus.step_req = 1'b0;
        n = 0; hi = 0;
        for (int i = 4; i <= 12; i++) begin
            tick(1);
            if (bus.clk_en) n++;
            if (bus.clock) hi++;
            if (i == 6) chk("step_mid_state", 32'(bus.state_out), 2);
            if (i == 7) chk("step_end_state", 32'(bus.state_out), 0);
        end
        chk("step_one_en", n, 1);
        chk("step_high_cycles", hi, 3);

        // Divisor 5 -> 1 written mid-high: applied on the falling toggle.
        set_div(5);
        bus.run_req = 1'b1;
        tick(9);
        chk("dw_high", 32'(bus.clock), 1);
        bus.div_wr = 1'b1;
        bus.div_in = 1;
        tick(1);
        bus.div_wr = 1'b0;
        tick(2);
        chk("dw_still_high", 32'(bus.clock), 1);
        chk("dw_old_div", bus.cur_div, 5);
        tick(1);
        chk("dw_fall", 32'(bus.clock), 0);
        chk("dw_new_div", bus.cur_div, 1);
        tick(1);
        chk("dw_low2", 32'(bus.clock), 0);
        tick(1);
        chk("dw_rise", 32'(bus.clock), 1);
        chk("dw_rise_en", 32'(bus.clk_en), 1);

        // halt_in stops the run; run_req alone cannot restart.
        bus.halt_in = 1'b1;
        tick(1);
        chk("halt_stop", 32'(bus.state_out), 3);
        tick(3);
        chk("halt_halt", 32'(bus.state_out), 0);
        tick(10);
        chk("halt_no_restart", 32'(bus.state_out), 0);
        chk("halt_clock0", 32'(bus.clock), 0);

        // Debug step is honoured under halt_in.
        bus.step_req = 1'b1;
        tick(1);
        bus.step_req = 1'b0;
        chk("hstep_state", 32'(bus.state_out), 2);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus.clk_en) n++;
        end
        chk("hstep_one_en", n, 1);
        chk("hstep_back", 32'(bus.state_out), 0);

        // Reset in the middle of a high half.
        bus.step_req = 1'b1;
        tick(1);
        bus.step_req = 1'b0;
        tick(2);
        chk("rmid_high", 32'(bus.clock), 1);
        reset = 1'b1;
        tick(1);
        chk("rmid_clock", 32'(bus.clock), 0);
        chk("rmid_state", 32'(bus.state_out), 0);
        chk("rmid_en", 32'(bus.clk_en), 0);
        chk("rmid_div", bus.cur_div, 5);
        reset = 1'b0;
        bus.halt_in = 1'b0;
        bus.run_req = 1'b0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
